// File: rtl/acc_pkg.sv
// Shared fixed-point definitions for the convolution datapath (mul -> psum_acc).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package acc_pkg;

  // Default Q(IW).(FW) format and accumulator guard bits.
  localparam int DEF_IW = 24;
  localparam int DEF_FW = 8;
  localparam int DEF_GW = 8;

  // Data width of one product / result, and the guarded accumulator width.
  localparam int DW = DEF_IW + DEF_FW;
  localparam int AW = DW + DEF_GW;

  // Saturation limits of a DW-bit signed result.
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  // Signed data word shared with the multiplier output.
  typedef logic signed [DW-1:0] data_t;
  // Guarded accumulator word.
  typedef logic signed [AW-1:0] acc_t;

  // Sign-extend a data word to accumulator width.
  function automatic acc_t sext(input data_t d);
    return {{DEF_GW{d[DW-1]}}, d};
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Clamps a wide signed accumulator value into a narrower signed word; ReLU when PSUM_ACC_RELU_EN is defined.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module sat_clip
  import acc_pkg::*;
#(
  parameter int IN_W  = AW,
  parameter int OUT_W = DW
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Bits that must all equal the result sign for the value to fit OUT_W.
  localparam int HW = IN_W - OUT_W + 1;

  logic [HW-1:0]           top_bits;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic signed [OUT_W-1:0] clip;

  assign top_bits = din[IN_W-1 -: HW];

  // Detect overflow from the redundant sign bits and pick the clamp value.
  always_comb begin
    pos_ovf = !din[IN_W-1] && (top_bits != {HW{1'b0}});
    neg_ovf =  din[IN_W-1] && (top_bits != {HW{1'b1}});
    if (pos_ovf) begin
      clip = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (neg_ovf) begin
      clip = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      clip = din[OUT_W-1:0];
    end
  end

  // Optional rectification after the clamp.
  always_comb begin
`ifdef PSUM_ACC_RELU_EN
    dout = clip[OUT_W-1] ? {OUT_W{1'b0}} : clip;
`else
    dout = clip;
`endif
  end

endmodule

// File: rtl/psum_acc.sv
// Accumulates ACC_LEN signed products plus a channel bias, saturates to IW+FW bits (ReLU if PSUM_ACC_RELU_EN).
// Latency: result valid the cycle after the last beat of a group is accepted; one beat per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a held result stalls input until drained.
module psum_acc
  import acc_pkg::*;
#(
  parameter int IW      = DEF_IW,
  parameter int FW      = DEF_FW,
  parameter int ACC_LEN = 9,
  parameter int GW      = DEF_GW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [IW+FW-1:0]  in_data,
  output logic                     in_ready,
  input  logic signed [IW+FW-1:0]  bias,
  input  logic                     flush,
  output logic                     out_valid,
  output logic signed [IW+FW-1:0]  out_data,
  input  logic                     out_ready
);

  localparam int DW_T = IW + FW;
  localparam int AW_T = DW_T + GW;
  localparam int CW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  logic [CW-1:0]          cnt;
  logic signed [AW_T-1:0] sum;
  logic signed [DW_T-1:0] bias_q;
  logic signed [DW_T-1:0] bias_eff;
  logic signed [AW_T-1:0] in_ext;
  logic signed [AW_T-1:0] bias_ext;
  logic signed [AW_T-1:0] total;
  logic signed [DW_T-1:0] clipped;
  logic                   accept;
  logic                   last_beat;

  // The output slot frees in the same cycle it drains.
  assign in_ready = !out_valid || out_ready;

  // Beat acceptance (flush drops a concurrent beat) and the group-final sum.
  always_comb begin
    accept    = in_valid && in_ready && !flush;
    last_beat = (cnt == LAST);
    // A one-beat group has no earlier beat to have registered the bias.
    bias_eff  = (ACC_LEN == 1) ? bias : bias_q;
    in_ext    = {{GW{in_data[DW_T-1]}}, in_data};
    bias_ext  = {{GW{bias_eff[DW_T-1]}}, bias_eff};
    total     = sum + in_ext + bias_ext;
  end

  sat_clip #(
    .IN_W  (AW_T),
    .OUT_W (DW_T)
  ) u_sat_clip (
    .din  (total),
    .dout (clipped)
  );

  // Partial-sum, beat counter and per-group bias registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sum    <= '0;
      bias_q <= '0;
    end else if (flush) begin
      cnt <= '0;
      sum <= '0;
    end else if (accept) begin
      if (cnt == '0) begin
        bias_q <= bias;
      end
      if (last_beat) begin
        cnt <= '0;
        sum <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        sum <= sum + in_ext;
      end
    end
  end

  // Result register: load on group completion, otherwise clear valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && last_beat) begin
      out_valid <= 1'b1;
      out_data  <= clipped;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
// Directed bench for psum_acc: group-level reference model plus literal expectations.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low on completion.
module tb_psum_acc;

  localparam int ACC_LEN = 9;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_ready;
  logic signed [31:0] bias = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic signed [31:0] out_data;
  logic               out_ready = 1'b1;

  int  n_total = 0;
  int  n_pass  = 0;
  bit  chk_en  = 1'b0;

  psum_acc #(
    .IW      (24),
    .FW      (8),
    .ACC_LEN (ACC_LEN),
    .GW      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bias      (bias),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (group level) ----------------
  longint grp[$];
  longint m_bias = 0;
  longint m_dat  = 0;
  bit     m_vld  = 1'b0;

  function automatic longint ref_result(input longint s);
    longint r;
    if (s > 64'sd2147483647) r = 64'sd2147483647;
    else if (s < -64'sd2147483648) r = -64'sd2147483648;
    else r = s;
`ifdef PSUM_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    longint s;
    bit     rdy;
    bit     done;
    if (rst) begin
      m_vld  = 1'b0;
      m_dat  = 0;
      m_bias = 0;
      grp.delete();
    end else begin
      rdy  = !m_vld || out_ready;
      done = 1'b0;
      if (flush) begin
        grp.delete();
      end else if (in_valid && rdy) begin
        if (grp.size() == 0) m_bias = bias;
        grp.push_back(longint'(in_data));
        if (grp.size() == ACC_LEN) begin
          s = m_bias;
          foreach (grp[i]) s += grp[i];
          m_dat = ref_result(s);
          done  = 1'b1;
          grp.delete();
        end
      end
      if (done) m_vld = 1'b1;
      else if (m_vld && out_ready) m_vld = 1'b0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", longint'(in_ready), longint'(!m_vld || out_ready));
      chk("model_out_valid", longint'(out_valid), longint'(m_vld));
      chk("model_out_data", longint'(out_data), m_dat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic signed [31:0] d, input logic signed [31:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    step();
  endtask

  task automatic send_beats(input int n, input logic signed [31:0] d, input logic signed [31:0] b);
    for (int i = 0; i < n; i++) send_beat(d, b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    longint neg_exp;
    longint negsat_exp;
`ifdef PSUM_ACC_RELU_EN
    neg_exp    = 0;
    negsat_exp = 0;
`else
    neg_exp    = -4608;
    negsat_exp = -64'sd2147483648;
`endif

    // Reset.
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_in_ready", longint'(in_ready), 1);

    // Nine beats of 1.0 plus bias 0.5 -> 9.5 = 2432.
    send_beats(9, 32'sd256, 32'sd128);
    in_valid = 1'b0;
    chk("basic_valid", longint'(out_valid), 1);
    chk("basic_data", longint'(out_data), 2432);
    idle(2);

    // Two back-to-back negative groups with no gap.
    send_beats(9, -32'sd512, 32'sd0);
    chk("b2b_first_data", longint'(out_data), neg_exp);
    chk("b2b_first_in_ready", longint'(in_ready), 1);
    send_beats(9, -32'sd512, 32'sd0);
    in_valid = 1'b0;
    chk("b2b_second_valid", longint'(out_valid), 1);
    chk("b2b_second_data", longint'(out_data), neg_exp);
    idle(2);

    // Positive and negative saturation.
    send_beats(9, 32'sh7FFF_FF00, 32'sh7FFF_FFFF);
    in_valid = 1'b0;
    chk("sat_pos", longint'(out_data), 64'sd2147483647);
    idle(1);
    send_beats(9, 32'sh8000_0100, 32'sh8000_0000);
    in_valid = 1'b0;
    chk("sat_neg", longint'(out_data), negsat_exp);
    idle(2);

    // Backpressure on completion.
    out_ready = 1'b0;
    send_beats(9, 32'sd256, 32'sd0);
    in_valid = 1'b1;
    in_data  = 32'sd7777;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_data", longint'(out_data), 2304);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", longint'(in_ready), 1);
    step();
    chk("drain_valid", longint'(out_valid), 0);
    idle(1);

    // Flush after four beats; the beat presented with flush is dropped.
    send_beats(4, 32'sd1000, 32'sd50);
    in_valid = 1'b1;
    in_data  = 32'sd9999;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    send_beats(9, 32'sd256, 32'sd0);
    in_valid = 1'b0;
    chk("flush_data", longint'(out_data), 2304);
    idle(2);

    // Reset with a held result.
    out_ready = 1'b0;
    send_beats(9, 32'sd256, 32'sd5);
    in_valid = 1'b0;
    chk("held_before_rst", longint'(out_data), 2309);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_held_valid", longint'(out_valid), 0);
    chk("rst_held_data", longint'(out_data), 0);
    chk("rst_held_in_ready", longint'(in_ready), 1);

    // Reset mid-group; the partial sum must not leak into the next group.
    out_ready = 1'b1;
    send_beats(5, 32'sd100, 32'sd3);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", longint'(out_valid), 0);
    send_beats(9, 32'sd256, 32'sd1);
    in_valid = 1'b0;
    chk("post_rst_data", longint'(out_data), 2305);
    idle(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psum_acc.md
# psum_acc

Partial-sum accumulator sitting directly downstream of the fixed-point multiplier (`mul`) in the RepVGG convolution datapath. Accumulates a fixed-length group of signed Q(IW).(FW) products (one kernel window × input channels), adds a per-output-channel bias, saturates back to IW+FW bits, and presents the result to the next stage over a valid/ready handshake. Products arrive one per cycle, aligned by the upstream controller to the multiplier's one-cycle latency.

## Interface
- `IW`, 24, integer bits of the fixed-point format (matches multiplier)
- `FW`, 8, fractional bits of the fixed-point format
- `ACC_LEN`, 9, products per group (≥1)
- `GW`, 8, guard bits on the accumulator; internal width AW = IW+FW+GW

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  product beat valid
- `in_data`  in  IW+FW signed  product (`mul.res`)
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `bias`  in  IW+FW signed  channel bias, sampled on first beat of a group
- `flush`  in  1  abort current group, discard partial sum
- `out_valid`  out  1  result held valid
- `out_data`  out  IW+FW signed  saturated group result
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`

## Operation
- State: `cnt` (0..ACC_LEN-1), `sum` (AW signed), `bias_q`, output register + `out_valid`.
- `in_ready = !out_valid || out_ready` (output slot frees same cycle it drains).
- Accepted beat, `cnt==0`: `bias_q <= bias`.
- Accepted beat, `cnt<ACC_LEN-1`: `sum <= sum + sext(in_data)`, `cnt++`.
- Accepted beat, `cnt==ACC_LEN-1`: `t = sum + sext(in_data) + sext(bias_eff)` where bias_eff = `bias` if ACC_LEN==1 else `bias_q`; `out_data <= sat(t)`, `out_valid <= 1`, `sum <= 0`, `cnt <= 0`.
- `sat`: clamp to [−2^(IW+FW−1), 2^(IW+FW−1)−1]; no rescaling (products already in Q(IW).(FW)).
- Output drain: `out_valid && out_ready` with no new completion → `out_valid <= 0`. Drain and completion same cycle → new result loaded, `out_valid` stays 1.
- `flush`: `sum <= 0`, `cnt <= 0`; beat presented same cycle is dropped (flush wins). Held output unaffected.
- `in_valid` low: no state change (bubbles allowed mid-group).

## Timing
- Reset: `out_valid=0`, `out_data=0`, `sum=0`, `cnt=0`, `bias_q=0`; `in_ready=1` after reset.
- Latency: last beat accepted at edge N → `out_valid=1` after edge N.
- Throughput: one beat/cycle sustained with `out_ready=1`; back-to-back groups with no gap.
- Stall: `out_valid && !out_ready` → `in_ready=0`; `out_data` stable until drained.
- `rst` mid-group or with output held: everything returns to reset values next edge, result lost.

## Configuration
- `PSUM_ACC_RELU_EN` defined: ReLU applied after saturation (negative → 0).
- Not defined: saturated signed result passed unchanged.

## Structure
- Package `acc_pkg`: `DW = IW+FW`, `AW`, `SAT_MAX`/`SAT_MIN` constants, signed data typedef shared with `mul`.
- One sub-module `sat_clip` (AW → DW clamp, optional ReLU under the macro); rest in `psum_acc`.

## Test plan
- ACC_LEN=9, nine beats of 256 (1.0), bias 128 → `out_data=2432` one cycle after 9th beat.
- Two back-to-back groups, `out_ready=1`: products −512×9, bias 0 → −4608 (macro off) / 0 (macro on); second group follows with no idle cycle.
- Saturation: nine beats of 0x7FFF_FF00, bias 0x7FFF_FFFF → `0x7FFF_FFFF`; negative mirror → `0x8000_0000`.
- Backpressure: `out_ready=0` on completion → `in_ready=0`, output stable 5 cycles; raise `out_ready` → drain, `in_ready=1` same cycle.
- `flush` after 4 beats, then 9 beats of 256, bias 0 → 2304 (partial sum discarded).
- `rst` asserted after 5 beats with output held → all outputs zero next edge; fresh group yields correct sum.
